// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the physical-memory responder.
//   lc3b_line     : one 128-bit cache line
//   lc3b_pmem_op  : operation carried by a pmem transaction
//   pmem_state_e  : responder FSM states
//   sat_inc16     : saturating 16-bit increment for event counters
package lc3b_types;

  typedef logic [127:0] lc3b_line;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } lc3b_pmem_op;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } pmem_state_e;

  localparam lc3b_line LINE_ZERO = 128'd0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/pmem_array.sv
// Line storage for the pmem responder: 2**DEPTH_LOG2 lines of 128 bits with
// a single synchronous port.
//   clk, reset_n : clock, async active-low reset (read register only)
//   en           : port access this cycle
//   we           : 1 = write wdata into line idx, 0 = read line idx
//   idx, wdata   : line index and write data
//   rdata        : registered read data; zero in any cycle after a non-read
// Storage contents are deliberately not reset.
module pmem_array
  import lc3b_types::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  lc3b_line              wdata,
  output lc3b_line              rdata
);

  lc3b_line mem_r [0:(2**DEPTH_LOG2)-1];

  // Line write; suppressed while reset is held so an aborted transfer never lands.
  always_ff @(posedge clk) begin
    if (reset_n && en && we) begin
      mem_r[idx] <= wdata;
    end
  end

  // Registered read; the register returns to zero after every non-read cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= LINE_ZERO;
    end else if (en && !we) begin
      rdata <= mem_r[idx];
    end else begin
      rdata <= LINE_ZERO;
    end
  end

endmodule

// File: rtl/pmem_responder.sv
// Responder end of the 128-bit line-transfer pmem protocol. Accepts one
// read or write at a time, answers with a one-cycle pmem_resp exactly
// LATENCY cycles after acceptance, and stores lines in pmem_array.
//   clk, reset_n            : clock, async active-low reset
//   pmem_read, pmem_write   : requests, held by the initiator until pmem_resp
//   pmem_address            : byte address, bits [3:0] ignored
//   pmem_wdata              : write line
//   pmem_resp               : completion strobe
//   pmem_rdata              : read line, nonzero only in the resp cycle of a read
//   proto_err               : sticky protocol-violation flag
//   rd_count, wr_count      : saturating completed-transfer counters
module pmem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY    = 24,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [15:0] pmem_address,
  input  lc3b_line    pmem_wdata,
  output logic        pmem_resp,
  output lc3b_line    pmem_rdata,
  output logic        proto_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  // Acceptance edge plus LATENCY-1 further edges lands the strobe in cycle t+LATENCY.
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  pmem_state_e           state_r, state_next_s;
  logic [7:0]            cnt_r, cnt_next_s;
  lc3b_pmem_op           op_r, live_op_s, txn_op_s;
  logic [11:0]           line_addr_r;
  lc3b_line              wdata_r, txn_wdata_s;
  logic [DEPTH_LOG2-1:0] txn_idx_s;
  logic                  req_s, accept_s, commit_s, err_s;
  logic                  unused_addr_bits_s;

  assign unused_addr_bits_s = ^pmem_address[3:0];

  // Next-state, counter and per-cycle protocol checks.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    commit_s     = 1'b0;
    err_s        = 1'b0;
    req_s        = pmem_read | pmem_write;
    live_op_s    = pmem_write ? WRITE : READ;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          accept_s = 1'b1;
          err_s    = pmem_read & pmem_write;
          if (LATENCY == 1) begin
            state_next_s = ST_RESP;
            commit_s     = 1'b1;
          end else begin
            state_next_s = ST_BUSY;
            cnt_next_s   = CNT_LOAD;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Live inputs only feed error detection; the transfer uses latched values.
        err_s = !req_s || (pmem_address[15:4] != line_addr_r) || (live_op_s != op_r);
        if (cnt_r == 8'd1) begin
          state_next_s = ST_RESP;
          commit_s     = 1'b1;
          cnt_next_s   = 8'd0;
        end else begin
          cnt_next_s = cnt_r - 8'd1;
        end
      end
      ST_RESP: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // With LATENCY=1 the commit happens on the acceptance edge, so use live inputs in IDLE.
  always_comb begin
    if (state_r == ST_IDLE) begin
      txn_op_s    = live_op_s;
      txn_idx_s   = pmem_address[DEPTH_LOG2+3:4];
      txn_wdata_s = pmem_wdata;
    end else begin
      txn_op_s    = op_r;
      txn_idx_s   = line_addr_r[DEPTH_LOG2-1:0];
      txn_wdata_s = wdata_r;
    end
  end

  // FSM state, latency counter and latched request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      op_r        <= READ;
      line_addr_r <= 12'd0;
      wdata_r     <= LINE_ZERO;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (accept_s) begin
        op_r        <= live_op_s;
        line_addr_r <= pmem_address[15:4];
        wdata_r     <= pmem_wdata;
      end
    end
  end

  // Registered strobe, sticky error flag and completion counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pmem_resp <= 1'b0;
      proto_err <= 1'b0;
      rd_count  <= 16'd0;
      wr_count  <= 16'd0;
    end else begin
      pmem_resp <= commit_s;
      proto_err <= proto_err | err_s;
      if (commit_s && (txn_op_s == WRITE)) begin
        wr_count <= sat_inc16(wr_count);
      end
      if (commit_s && (txn_op_s == READ)) begin
        rd_count <= sat_inc16(rd_count);
      end
    end
  end

  pmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (commit_s),
    .we     (txn_op_s == WRITE),
    .idx    (txn_idx_s),
    .wdata  (txn_wdata_s),
    .rdata  (pmem_rdata)
  );

endmodule

// File: tb/tb_pmem_responder.sv
// Testbench for pmem_responder: one instance with LATENCY=24, one with LATENCY=1.
module tb_pmem_responder;
  logic         clk = 1'b0;
  logic         reset_n;
  logic         sel;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;

  logic         rd24, wr24, rd1, wr1;
  logic         resp24, resp1, err24, err1;
  logic [127:0] rdata24, rdata1;
  logic [15:0]  rdc24, wrc24, rdc1, wrc1;
  logic         obs_resp, obs_err;
  logic [127:0] obs_rdata;
  logic [15:0]  obs_rdc, obs_wrc;

  assign rd24 = pmem_read & ~sel;
  assign wr24 = pmem_write & ~sel;
  assign rd1  = pmem_read & sel;
  assign wr1  = pmem_write & sel;
  assign obs_resp  = sel ? resp1 : resp24;
  assign obs_rdata = sel ? rdata1 : rdata24;
  assign obs_err   = sel ? err1 : err24;
  assign obs_rdc   = sel ? rdc1 : rdc24;
  assign obs_wrc   = sel ? wrc1 : wrc24;

  pmem_responder #(.LATENCY(24), .DEPTH_LOG2(8)) u_dut24 (
    .clk(clk), .reset_n(reset_n), .pmem_read(rd24), .pmem_write(wr24),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(resp24),
    .pmem_rdata(rdata24), .proto_err(err24), .rd_count(rdc24), .wr_count(wrc24));

  pmem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .pmem_read(rd1), .pmem_write(wr1),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(resp1),
    .pmem_rdata(rdata1), .proto_err(err1), .rd_count(rdc1), .wr_count(wrc1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Entered at a negedge. Drives one request, waits (bounded) for the strobe.
  task automatic do_txn(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [127:0] wd, input int mod_at, input logic [15:0] mod_addr,
                        input logic mod_drop, input logic tail, output int lat,
                        output int stamp, output logic [127:0] rdat, output logic quiet);
    lat = 0; stamp = 0; rdat = 128'd0; quiet = 1'b1;
    pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = wd;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (obs_resp === 1'b1) begin
        lat = k; stamp = cyc; rdat = obs_rdata;
        break;
      end
      if (obs_rdata !== 128'd0) quiet = 1'b0;
      if (k == mod_at) begin
        if (mod_drop) begin
          pmem_read = 1'b0; pmem_write = 1'b0;
        end else begin
          pmem_address = mod_addr;
        end
      end
    end
    pmem_read = 1'b0; pmem_write = 1'b0;
    if (tail) begin
      @(negedge clk);
      if (obs_resp !== 1'b0 || obs_rdata !== 128'd0) quiet = 1'b0;
    end
  endtask

  typedef struct {
    logic rd; logic wr; logic [15:0] addr; logic [127:0] wd;
    logic [127:0] exp_rdata; logic [15:0] exp_rd; logic [15:0] exp_wr;
  } vec_t;

  localparam logic [127:0] D_BEEF = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] D_A    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D_B    = 128'hA5A5_5A5A_C3C3_3C3C_0F0F_F0F0_9696_6969;
  localparam logic [127:0] D_JUNK = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;

  vec_t         vecs [7];
  int           lat, st1, st2;
  logic [127:0] rdat;
  logic         quiet, seen;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'h0120, D_BEEF, 128'd0,  16'd0, 16'd1};
    vecs[1] = '{1'b1, 1'b0, 16'h012C, D_JUNK, D_BEEF,  16'd1, 16'd1};
    vecs[2] = '{1'b0, 1'b1, 16'h1130, D_A,    128'd0,  16'd1, 16'd2};
    vecs[3] = '{1'b1, 1'b0, 16'h0130, D_JUNK, D_A,     16'd2, 16'd2};
    vecs[4] = '{1'b0, 1'b1, 16'h0FF0, D_B,    128'd0,  16'd2, 16'd3};
    vecs[5] = '{1'b1, 1'b0, 16'hFFF8, D_JUNK, D_B,     16'd3, 16'd3};
    vecs[6] = '{1'b1, 1'b0, 16'h0120, D_JUNK, D_BEEF,  16'd4, 16'd3};

    reset_n = 1'b0; sel = 1'b0; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_address = 16'd0; pmem_wdata = 128'd0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk($sformatf("rst%0d_resp", s), obs_resp, 1'b0);
      chk($sformatf("rst%0d_rdata", s), obs_rdata, 128'd0);
      chk($sformatf("rst%0d_err", s), obs_err, 1'b0);
      chk($sformatf("rst%0d_counts", s), {obs_rdc, obs_wrc}, 32'd0);
    end
    sel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Table: basic writes/reads, offset and alias handling on LATENCY=24.
    for (int i = 0; i < 7; i++) begin
      do_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, 0, 16'd0, 1'b0, 1'b1,
             lat, st1, rdat, quiet);
      chk($sformatf("v%0d_lat", i), lat, 24);
      chk($sformatf("v%0d_rdata", i), rdat, vecs[i].exp_rdata);
      chk($sformatf("v%0d_quiet", i), quiet, 1'b1);
      chk($sformatf("v%0d_rd_count", i), obs_rdc, vecs[i].exp_rd);
      chk($sformatf("v%0d_wr_count", i), obs_wrc, vecs[i].exp_wr);
      chk($sformatf("v%0d_err", i), obs_err, 1'b0);
    end

    // LATENCY=1 back-to-back write then read of the same line.
    sel = 1'b1;
    do_txn(1'b0, 1'b1, 16'h0040, D_A, 0, 16'd0, 1'b0, 1'b0, lat, st1, rdat, quiet);
    chk("l1_wr_lat", lat, 1);
    do_txn(1'b1, 1'b0, 16'h0040, D_JUNK, 0, 16'd0, 1'b0, 1'b1, lat, st2, rdat, quiet);
    chk("l1_spacing", st2 - st1, 2);
    chk("l1_rdata", rdat, D_A);
    chk("l1_counts", {obs_rdc, obs_wrc}, {16'd1, 16'd1});
    chk("l1_err", obs_err, 1'b0);
    sel = 1'b0;

    // Read and write together: completes as a write, error is sticky.
    do_txn(1'b1, 1'b1, 16'h0200, D_B, 0, 16'd0, 1'b0, 1'b1, lat, st1, rdat, quiet);
    chk("both_lat", lat, 24);
    chk("both_rdata", rdat, 128'd0);
    chk("both_counts", {obs_rdc, obs_wrc}, {16'd4, 16'd4});
    chk("both_err", obs_err, 1'b1);
    do_txn(1'b1, 1'b0, 16'h0200, D_JUNK, 0, 16'd0, 1'b0, 1'b1, lat, st1, rdat, quiet);
    chk("both_rb_rdata", rdat, D_B);
    chk("both_err_sticky", obs_err, 1'b1);

    // Reset in the middle of a write: no strobe, no commit, counters cleared.
    do_txn(1'b0, 1'b1, 16'h0300, D_A, 0, 16'd0, 1'b0, 1'b1, lat, st1, rdat, quiet);
    chk("rst_pre_lat", lat, 24);
    pmem_write = 1'b1; pmem_address = 16'h0300; pmem_wdata = D_B;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (obs_resp !== 1'b0) seen = 1'b1;
    end
    reset_n = 1'b0; pmem_write = 1'b0;
    #1;
    chk("midrst_counts", {obs_rdc, obs_wrc}, 32'd0);
    chk("midrst_err", obs_err, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (obs_resp !== 1'b0) seen = 1'b1;
    end
    chk("midrst_no_resp", seen, 1'b0);
    do_txn(1'b1, 1'b0, 16'h0300, D_JUNK, 0, 16'd0, 1'b0, 1'b1, lat, st1, rdat, quiet);
    chk("midrst_rdata", rdat, D_A);
    chk("midrst_counts_after", {obs_rdc, obs_wrc}, {16'd1, 16'd0});

    // Address changed while busy: latched address wins, error raised.
    do_txn(1'b0, 1'b1, 16'h0400, D_BEEF, 0, 16'd0, 1'b0, 1'b1, lat, st1, rdat, quiet);
    do_txn(1'b0, 1'b1, 16'h0500, D_B, 0, 16'd0, 1'b0, 1'b1, lat, st1, rdat, quiet);
    chk("addr_pre_err", obs_err, 1'b0);
    do_txn(1'b1, 1'b0, 16'h0400, D_JUNK, 5, 16'h0500, 1'b0, 1'b1, lat, st1, rdat, quiet);
    chk("addr_lat", lat, 24);
    chk("addr_rdata", rdat, D_BEEF);
    chk("addr_err", obs_err, 1'b1);

    // Request dropped while busy: still completes, error raised.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("drop_pre_err", obs_err, 1'b0);
    do_txn(1'b1, 1'b0, 16'h0500, D_JUNK, 3, 16'd0, 1'b1, 1'b1, lat, st1, rdat, quiet);
    chk("drop_lat", lat, 24);
    chk("drop_rdata", rdat, D_B);
    chk("drop_err", obs_err, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
